// File: rtl/edge_anomaly_detector.sv
// edge_anomaly_detector: learns a min/max band of window edge counts, then flags out-of-band windows
// and raises a sticky alarm after a run of consecutive anomalies.
module edge_anomaly_detector #(
    parameter int DATA_WIDTH    = 8,
    parameter int TRAIN_WINDOWS = 16,
    parameter int MARGIN        = 4,
    parameter int ALARM_COUNT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] num_edges,
    input  logic                  data_vld,
    input  logic                  retrain,
    input  logic                  alarm_clr,
    output logic                  trained,
    output logic [DATA_WIDTH-1:0] baseline_min,
    output logic [DATA_WIDTH-1:0] baseline_max,
    output logic                  result_vld,
    output logic                  anomaly,
    output logic                  alarm,
    output logic [15:0]           anomaly_cnt
);
    localparam int CW = $clog2(TRAIN_WINDOWS) + 1;
    localparam int SW = $clog2(ALARM_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(TRAIN_WINDOWS - 1);
    localparam logic [SW-1:0] AMAX = SW'(ALARM_COUNT);
    localparam logic [DATA_WIDTH:0] MARG = (DATA_WIDTH + 1)'(MARGIN);

    typedef enum logic {TRAIN, DETECT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         win_cnt;
    logic [DATA_WIDTH-1:0] run_min, run_max, min_nxt, max_nxt;
    logic [DATA_WIDTH:0]   lo_ext, hi_ext;
    logic [SW-1:0]         streak, streak_nxt;
    logic                  accept, train_done, det, anom;

    assign trained = (state == DETECT);

    always_comb begin
        accept     = data_vld && !retrain;
        train_done = (state == TRAIN) && accept && (win_cnt == LAST);
        det        = (state == DETECT) && accept;
        min_nxt    = (win_cnt == '0 || num_edges < run_min) ? num_edges : run_min;
        max_nxt    = (win_cnt == '0 || num_edges > run_max) ? num_edges : run_max;
        // one extra bit exposes borrow/carry for the saturating band edges
        lo_ext     = {1'b0, min_nxt} - MARG;
        hi_ext     = {1'b0, max_nxt} + MARG;
        anom       = (num_edges < baseline_min) || (num_edges > baseline_max);
        streak_nxt = !anom ? '0 : (streak == AMAX) ? streak : streak + 1'b1;
        state_nxt  = retrain ? TRAIN : train_done ? DETECT : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= TRAIN;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt      <= '0;
            run_min      <= '0;
            run_max      <= '0;
            streak       <= '0;
            baseline_min <= '0;
            baseline_max <= '0;
            result_vld   <= 1'b0;
            anomaly      <= 1'b0;
            alarm        <= 1'b0;
            anomaly_cnt  <= '0;
        end else if (retrain) begin
            win_cnt      <= '0;
            run_min      <= '0;
            run_max      <= '0;
            streak       <= '0;
            baseline_min <= '0;
            baseline_max <= '0;
            result_vld   <= 1'b0;
            anomaly      <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            result_vld <= det;
            if (state == TRAIN && accept) begin
                win_cnt <= train_done ? '0 : win_cnt + 1'b1;
                run_min <= min_nxt;
                run_max <= max_nxt;
            end
            if (train_done) begin
                baseline_min <= lo_ext[DATA_WIDTH] ? '0 : lo_ext[DATA_WIDTH-1:0];
                baseline_max <= hi_ext[DATA_WIDTH] ? '1 : hi_ext[DATA_WIDTH-1:0];
            end
            if (det) begin
                anomaly <= anom;
                streak  <= streak_nxt;
                if (anom && anomaly_cnt != 16'hffff) anomaly_cnt <= anomaly_cnt + 16'd1;
            end
            // a set in the same cycle as a clear takes priority
            alarm <= (det && anom && streak_nxt == AMAX) ? 1'b1 : alarm_clr ? 1'b0 : alarm;
        end
    end
endmodule
